// File: rtl/vsync_tracker.sv
// Receive-side vertical timing tracker: recovers the line index from a vsync/blank
// pair, measures frame geometry, and qualifies lock over consecutive frames.
module vsync_tracker #(
  parameter int unsigned EXP_TOTAL   = 667,
  parameter int unsigned EXP_ACTIVE  = 600,
  parameter int unsigned EXP_SYNC    = 6,
  parameter int unsigned CHECK_EXP   = 1,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        line_clk,
  input  logic        rst_n,
  input  logic        vsync_in,
  input  logic        blank_in,
  output logic [10:0] y_crd,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] total_lines,
  output logic [10:0] active_lines,
  output logic [10:0] sync_width,
  output logic        timing_err
);

  // state    | meaning
  // SEARCH   | waiting for the first frame edge
  // MEASURE  | first full frame in progress, no reference yet
  // VERIFY   | comparing frames against the reference, counting matches
  // LOCKED   | timing stable, any deviation raises timing_err
  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  localparam logic [10:0] CNT_MAX = 11'h7FF;
  localparam logic [10:0] EXP_T   = 11'(EXP_TOTAL);
  localparam logic [10:0] EXP_A   = 11'(EXP_ACTIVE);
  localparam logic [10:0] EXP_S   = 11'(EXP_SYNC);
  localparam logic [2:0]  LOCK_N  = 3'(LOCK_FRAMES);

  state_t      state_q, state_d;
  logic        blank_q;
  logic [10:0] line_cnt_q, line_cnt_d;
  logic [10:0] act_cnt_q, act_cnt_d;
  logic [10:0] syn_cnt_q, syn_cnt_d;
  logic [2:0]  match_q, match_d;
  logic [10:0] ref_t_q, ref_t_d;
  logic [10:0] ref_a_q, ref_a_d;
  logic [10:0] ref_s_q, ref_s_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic        frame_start_q;
  logic [10:0] total_q, active_q, sync_q;
  logic        snap_en;

  logic        edge_e;
  logic        timeout;
  logic [10:0] meas_t;
  logic        exp_ok;
  logic        ref_eq;
  logic [2:0]  match_inc;

  assign edge_e    = ~blank_in & blank_q;
  assign meas_t    = line_cnt_q + 11'd1;
  assign exp_ok    = (CHECK_EXP == 0) ||
                     ((meas_t == EXP_T) && (act_cnt_q == EXP_A) && (syn_cnt_q == EXP_S));
  assign ref_eq    = (meas_t == ref_t_q) && (act_cnt_q == ref_a_q) && (syn_cnt_q == ref_s_q);
  assign match_inc = match_q + 3'd1;

  // The edge line belongs to the new frame, so counters restart at 1 when it qualifies.
  always_comb begin
    line_cnt_d = (line_cnt_q == CNT_MAX) ? CNT_MAX : line_cnt_q + 11'd1;
    act_cnt_d  = (~blank_in && act_cnt_q != CNT_MAX) ? act_cnt_q + 11'd1 : act_cnt_q;
    syn_cnt_d  = (~vsync_in && syn_cnt_q != CNT_MAX) ? syn_cnt_q + 11'd1 : syn_cnt_q;
    if (edge_e) begin
      line_cnt_d = 11'd0;
      act_cnt_d  = {10'd0, ~blank_in};
      syn_cnt_d  = {10'd0, ~vsync_in};
    end
  end

  assign timeout = ~edge_e && (line_cnt_d == CNT_MAX) && (state_q != SEARCH);

  always_ff @(posedge line_clk) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      blank_q       <= 1'b1;
      line_cnt_q    <= '0;
      act_cnt_q     <= '0;
      syn_cnt_q     <= '0;
      match_q       <= '0;
      ref_t_q       <= '0;
      ref_a_q       <= '0;
      ref_s_q       <= '0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
      frame_start_q <= 1'b0;
      total_q       <= '0;
      active_q      <= '0;
      sync_q        <= '0;
    end else begin
      state_q       <= state_d;
      blank_q       <= blank_in;
      line_cnt_q    <= line_cnt_d;
      act_cnt_q     <= act_cnt_d;
      syn_cnt_q     <= syn_cnt_d;
      match_q       <= match_d;
      ref_t_q       <= ref_t_d;
      ref_a_q       <= ref_a_d;
      ref_s_q       <= ref_s_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
      frame_start_q <= edge_e;
      if (snap_en) begin
        total_q  <= meas_t;
        active_q <= act_cnt_q;
        sync_q   <= syn_cnt_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = SEARCH;
    end else if (edge_e) begin
      case (state_q)
        SEARCH:  state_d = MEASURE;
        MEASURE: state_d = VERIFY;
        VERIFY:  if (ref_eq && exp_ok && match_inc >= LOCK_N) state_d = LOCKED;
        LOCKED:  if (!ref_eq) state_d = VERIFY;
        default: state_d = SEARCH;
      endcase
    end
  end

  always_comb begin
    match_d  = match_q;
    ref_t_d  = ref_t_q;
    ref_a_d  = ref_a_q;
    ref_s_d  = ref_s_q;
    err_d    = 1'b0;
    snap_en  = 1'b0;
    if (timeout) begin
      match_d = '0;
      err_d   = (state_q == LOCKED);
    end else if (edge_e) begin
      snap_en = (state_q != SEARCH);
      case (state_q)
        MEASURE: begin
          ref_t_d = meas_t;
          ref_a_d = act_cnt_q;
          ref_s_d = syn_cnt_q;
          match_d = {2'b00, exp_ok};
        end
        VERIFY: begin
          if (ref_eq && exp_ok) begin
            match_d = match_inc;
          end else begin
            ref_t_d = meas_t;
            ref_a_d = act_cnt_q;
            ref_s_d = syn_cnt_q;
            match_d = {2'b00, exp_ok};
          end
        end
        LOCKED: begin
          if (!ref_eq) begin
            err_d   = 1'b1;
            ref_t_d = meas_t;
            ref_a_d = act_cnt_q;
            ref_s_d = syn_cnt_q;
            match_d = '0;
          end
        end
        default: ;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  assign y_crd        = line_cnt_q;
  assign frame_start  = frame_start_q;
  assign locked       = locked_q;
  assign total_lines  = total_q;
  assign active_lines = active_q;
  assign sync_width   = sync_q;
  assign timing_err   = err_q;

endmodule

// File: tb/tb_vsync_tracker.sv
// Directed bench for vsync_tracker: one instance with expected-value checking and one
// self-consistency instance share the same vsync/blank stimulus.
module tb_vsync_tracker;

  typedef struct {
    int n;       // lines in this frame
    int sync0;   // first vsync-low line (6 lines long)
    int tot;     // expected snapshot after this frame's opening edge
    int act;
    int syn;
    int lk1;
    int er1;
    int lk0;
    int er0;
  } step_t;

  logic        line_clk = 1'b0;
  logic        rst_n;
  logic        vsync_in;
  logic        blank_in;
  logic [10:0] y1, tot1, act1, syn1;
  logic        fs1, lk1, er1;
  logic [10:0] y0, tot0, act0, syn0;
  logic        fs0, lk0, er0;

  int n_checks = 0;
  int n_err    = 0;
  step_t steps[28];

  vsync_tracker #(.CHECK_EXP(1), .LOCK_FRAMES(2)) dut1 (
    .line_clk(line_clk), .rst_n(rst_n), .vsync_in(vsync_in), .blank_in(blank_in),
    .y_crd(y1), .frame_start(fs1), .locked(lk1), .total_lines(tot1),
    .active_lines(act1), .sync_width(syn1), .timing_err(er1));

  vsync_tracker #(.CHECK_EXP(0), .LOCK_FRAMES(2)) dut0 (
    .line_clk(line_clk), .rst_n(rst_n), .vsync_in(vsync_in), .blank_in(blank_in),
    .y_crd(y0), .frame_start(fs0), .locked(lk0), .total_lines(tot0),
    .active_lines(act0), .sync_width(syn0), .timing_err(er0));

  always #5 line_clk = ~line_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_line(input logic b, input logic v);
    blank_in = b;
    vsync_in = v;
    @(posedge line_clk);
    #1;
  endtask

  task automatic play_step(input int idx, input step_t s);
    int stray;
    string tag;
    stray = 0;
    tag = $sformatf("step%0d", idx);
    for (int i = 0; i < s.n; i++) begin
      drive_line(i >= 600, !(i >= s.sync0 && i < s.sync0 + 6));
      if (i == 0) begin
        chk({tag, " frame_start1"}, int'(fs1), 1);
        chk({tag, " frame_start0"}, int'(fs0), 1);
        chk({tag, " y_crd0"},       int'(y1), 0);
        chk({tag, " total1"},       int'(tot1), s.tot);
        chk({tag, " active1"},      int'(act1), s.act);
        chk({tag, " sync1"},        int'(syn1), s.syn);
        chk({tag, " total0"},       int'(tot0), s.tot);
        chk({tag, " sync0"},        int'(syn0), s.syn);
        chk({tag, " locked1"},      int'(lk1), s.lk1);
        chk({tag, " err1"},         int'(er1), s.er1);
        chk({tag, " locked0"},      int'(lk0), s.lk0);
        chk({tag, " err0"},         int'(er0), s.er0);
      end else begin
        stray += int'(er1) + int'(er0);
        if (i == 1) chk({tag, " frame_start_drop"}, int'(fs1), 0);
      end
      if (i == s.n - 1) begin
        chk({tag, " y_crd_last1"}, int'(y1), s.n - 1);
        chk({tag, " y_crd_last0"}, int'(y0), s.n - 1);
      end
    end
    chk({tag, " stray_err"}, stray, 0);
  endtask

  initial begin
    int e1, e0, stray;

    //            n    sync0 tot  act  syn lk1 er1 lk0 er0
    steps[0]  = '{667, 637,    0,   0,  0,  0,  0,  0,  0};
    steps[1]  = '{667, 637,  667, 600,  6,  0,  0,  0,  0};
    steps[2]  = '{667, 637,  667, 600,  6,  1,  0,  1,  0};
    steps[3]  = '{668, 637,  667, 600,  6,  1,  0,  1,  0};
    steps[4]  = '{668, 637,  668, 600,  6,  0,  1,  0,  1};
    steps[5]  = '{668, 637,  668, 600,  6,  0,  0,  0,  0};
    steps[6]  = '{668, 637,  668, 600,  6,  0,  0,  1,  0};
    steps[7]  = '{667, 637,  668, 600,  6,  0,  0,  1,  0};
    steps[8]  = '{667, 637,  667, 600,  6,  0,  0,  0,  1};
    steps[9]  = '{667, 637,  667, 600,  6,  1,  0,  0,  0};
    steps[10] = '{667, 637,  667, 600,  6,  1,  0,  1,  0};
    steps[11] = '{667,   0,  667, 600,  6,  1,  0,  1,  0};
    steps[12] = '{667,   0,  667, 600,  6,  1,  0,  1,  0};
    steps[13] = '{667,   0,  667, 600,  6,  1,  0,  1,  0};
    steps[14] = '{700, 637,  667, 600,  6,  1,  0,  1,  0};
    steps[15] = '{700, 637,  700, 600,  6,  0,  1,  0,  1};
    steps[16] = '{700, 637,  700, 600,  6,  0,  0,  0,  0};
    steps[17] = '{700, 637,  700, 600,  6,  0,  0,  1,  0};
    steps[18] = '{667, 637,  700, 600,  6,  0,  0,  1,  0};
    steps[19] = '{667, 637,  667, 600,  6,  0,  0,  0,  1};
    steps[20] = '{667, 637,  667, 600,  6,  1,  0,  0,  0};
    steps[21] = '{667, 637,  667, 600,  6,  1,  0,  1,  0};
    // after timeout: SEARCH edge keeps old snapshot, then MEASURE, then lock
    steps[22] = '{667, 637,  667, 600,  6,  0,  0,  0,  0};
    steps[23] = '{667, 637,  667, 600,  6,  0,  0,  0,  0};
    steps[24] = '{667, 637,  667, 600,  6,  1,  0,  1,  0};
    // after mid-frame reset: blank_q=1 makes line 301 an edge, so lines 301..666 form a partial frame
    steps[25] = '{667, 637,  366, 299,  6,  0,  0,  0,  0};
    steps[26] = '{667, 637,  667, 600,  6,  0,  0,  0,  0};
    steps[27] = '{667, 637,  667, 600,  6,  1,  0,  1,  0};

    rst_n    = 1'b0;
    blank_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) begin
      @(posedge line_clk);
      #1;
    end
    chk("reset y_crd",    int'(y1), 0);
    chk("reset locked",   int'(lk1), 0);
    chk("reset total",    int'(tot1), 0);
    chk("reset err",      int'(er1), 0);
    chk("reset fs",       int'(fs0), 0);
    rst_n = 1'b1;

    for (int k = 0; k < 22; k++) play_step(k, steps[k]);

    // blank stuck high from a locked state
    e1 = 0;
    e0 = 0;
    for (int k = 0; k < 1500; k++) begin
      drive_line(1'b1, 1'b1);
      e1 += int'(er1);
      e0 += int'(er0);
    end
    chk("timeout err1 pulses", e1, 1);
    chk("timeout err0 pulses", e0, 1);
    chk("timeout y_crd1 sat",  int'(y1), 2047);
    chk("timeout y_crd0 sat",  int'(y0), 2047);
    chk("timeout locked1",     int'(lk1), 0);
    chk("timeout locked0",     int'(lk0), 0);

    for (int k = 22; k < 25; k++) play_step(k, steps[k]);

    // one-cycle reset at line 300 of a locked frame
    for (int i = 0; i < 300; i++) drive_line(1'b0, 1'b1);
    rst_n = 1'b0;
    drive_line(1'b0, 1'b1);
    rst_n = 1'b1;
    chk("midrst y_crd",  int'(y1), 0);
    chk("midrst fs",     int'(fs1), 0);
    chk("midrst locked", int'(lk1) + int'(lk0), 0);
    chk("midrst total",  int'(tot1) + int'(tot0), 0);
    chk("midrst active", int'(act1), 0);
    chk("midrst sync",   int'(syn1), 0);
    chk("midrst err",    int'(er1) + int'(er0), 0);
    stray = 0;
    for (int i = 301; i < 667; i++) begin
      drive_line(i >= 600, !(i >= 637 && i < 643));
      stray += int'(er1) + int'(er0);
      if (i == 301) chk("midrst edge fs", int'(fs1), 1);
      if (i == 302) chk("midrst state search->measure no lock", int'(lk1), 0);
    end
    chk("midrst stray err", stray, 0);

    for (int k = 25; k < 28; k++) play_step(k, steps[k]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vsync_tracker.md
Name: vsync_tracker

Overview:
- Receive-side counterpart of the vertical timing generator.
- Runs on the line clock (one tick per line) and consumes a vertical sync and blank pair from the generator or an external source.
- Recovers the line (y) coordinate, emits a frame-start pulse, and measures total, active and sync-width line counts.
- Declares lock after consistent frames and flags timing errors; feeds overlay/colour logic and self-check of the display path.

Parameters:
- EXP_TOTAL, 667, expected lines per frame (checked only when CHECK_EXP=1)
- EXP_ACTIVE, 600, expected visible lines per frame
- EXP_SYNC, 6, expected vsync-low lines per frame
- CHECK_EXP, 1, 1 = lock also requires match to EXP_* values; 0 = self-consistency only
- LOCK_FRAMES, 2, consecutive matching frames needed to assert locked (1..7)

Ports:
- line_clk  in  1  line-rate clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- vsync_in  in  1  vertical sync, active low
- blank_in  in  1  1 = blanked line, 0 = visible line
- y_crd  out  11  recovered line index, 0 = first visible line
- frame_start  out  1  one-cycle pulse on first visible line
- locked  out  1  timing stable
- total_lines  out  11  last measured lines per frame
- active_lines  out  11  last measured visible lines
- sync_width  out  11  last measured vsync-low lines
- timing_err  out  1  one-cycle pulse on mismatch or timeout while locked

Behaviour:
- Input registration:
  - blank_in is registered into blank_q.
  - Edge condition E = (blank_in==0 && blank_q==1), evaluated at a rising edge.
  - All outputs are registered. frame_start is high in the cycle following the edge at which E is true.
- Reset (rst_n=0 at an edge):
  - y_crd=0, frame_start=0, locked=0, total_lines=0, active_lines=0, sync_width=0, timing_err=0.
  - Internal counters are cleared, blank_q=1, state=SEARCH, match count=0.
  - Reset mid-frame discards the partial measurement; no err pulse is produced.
- Counters, per line:
  - line_cnt: set to 0 on E, else +1, saturating at 2047.
  - act_cnt: counts cycles with blank_in==0.
  - syn_cnt: counts cycles with vsync_in==0.
  - On E, act_cnt and syn_cnt restart at (blank_in==0 ? 1:0) and (vsync_in==0 ? 1:0) so the edge line is counted in the new frame.
  - act_cnt and syn_cnt saturate at 2047.
  - y_crd = line_cnt.
- Snapshot on E (frame = lines from one E to the next):
  - Frame values: T = line_cnt+1, A = act_cnt, S = syn_cnt.
  - Registered into total_lines, active_lines, sync_width only when state is not SEARCH.
  - In SEARCH, E only starts the first frame; outputs keep prior values.
- FSM:
  - SEARCH: on E -> MEASURE.
  - MEASURE: on E -> store T/A/S as reference; match=1 if (CHECK_EXP=0 or T/A/S equal EXP_*), else 0; -> VERIFY.
  - VERIFY: on E:
    - If T/A/S equal the reference (and EXP_* when CHECK_EXP=1), match+1; when match reaches LOCK_FRAMES, locked=1 -> LOCKED.
    - Otherwise reference = new values, match = (new values satisfy the CHECK_EXP condition ? 1:0), stay in VERIFY.
  - LOCKED: on E:
    - Mismatch to reference -> timing_err=1 for one cycle, locked=0, reference = new values, match=0 -> VERIFY.
    - Match -> stay.
- Timeout:
  - line_cnt reaching 2047 without E, in any state other than SEARCH -> state=SEARCH, locked=0.
  - timing_err pulses only if the state was LOCKED.
  - Counting holds at 2047 until the next E.
- Simultaneous events: rst_n has priority over E and timeout; E at the same edge as timeout is taken as E.
- frame_start pulses on every E regardless of state, including in SEARCH.
- blank_in stuck at 0 or 1 produces no E, so the timeout path applies.

Test Plan:
- Generator pattern (667 lines, blank low lines 0..599, vsync low lines 637..642), LOCK_FRAMES=2, CHECK_EXP=1 -> after 3rd E: total_lines=667, active_lines=600, sync_width=6; locked=1 the cycle after the 3rd E; y_crd counts 0..666 each frame.
- Locked, then one frame of 668 lines -> timing_err single-cycle pulse and locked=0 at the E ending that frame; relock after 2 further 668-line frames only if CHECK_EXP=0, else stays unlocked.
- Locked, then blank_in held at 1 -> y_crd saturates at 2047; timing_err pulses once; locked=0; state returns to SEARCH, and the next E gives frame_start but no measurement update.
- rst_n=0 for one cycle at line 300 of a locked frame -> all outputs 0 the next cycle, no timing_err; relock requires SEARCH, MEASURE and 2 matching frames.
- vsync low coincident with the E line (sync lines 0..5) -> sync_width=6, not 5 or 7; counts remain stable and lock is kept.
- CHECK_EXP=1 with 700-line self-consistent frames -> locked never asserts; total_lines=700 is still reported.
